spi_xfer_sequencer: RTL
=======================

SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: byte width of the tx/rx streams; shall equal the SPI controller DATA_WIDTH.
REQ-002 Parameter POLL_LIMIT, default 1024: maximum STAT reads per byte before timeout.
REQ-003 pclk_i  in  1  clock; all logic on its rising edge.
REQ-004 preset_i  in  1  reset; synchronous, active-high.
REQ-005 cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake.
REQ-006 cmd_len_i  in  8  byte count of the command, 0..255.
REQ-007 cmd_slave_i  in  2  target chip-select index, 0..3.
REQ-008 tx_valid_i / tx_ready_o / tx_data_i  in/out/in  1/1/DATA_WIDTH  transmit byte stream.
REQ-009 rx_valid_o / rx_ready_i / rx_data_o  out/in/out  1/1/DATA_WIDTH  received byte stream.
REQ-010 done_o, err_o  out  1, 1  completion pulse and error qualifier.
REQ-011 psel_o, penable_o, pwrite_o  out  1 each  APB master control.
REQ-012 paddr_o  out  8 and pwdata_o  out  32  APB address and write data.
REQ-013 prdata_i  in  32, pready_i  in  1, pslverr_i  in  1  APB responses from the SPI controller.

Function
REQ-014 The block shall act as the APB master feeding the SPI controller: CTRL 0x00, STAT 0x04, TXDATA 0x08, RXDATA 0x0C.
REQ-015 Each APB transfer shall use one SETUP cycle (psel=1, penable=0), then ACCESS (psel=1, penable=1) held until pready_i=1; paddr/pwrite/pwdata stay stable across both phases.
REQ-016 cmd_ready_o shall be 1 only in IDLE; a command is accepted when cmd_valid_i & cmd_ready_o, with len and slave captured.
REQ-017 If cmd_len_i=0, done_o shall pulse the next cycle with err_o=0 and no APB traffic.
REQ-018 State sequence: IDLE -> CFG_WR -> TX_WAIT -> TX_WR -> STAT_RD -> RX_RD -> RX_OUT -> (TX_WAIT if bytes remain, else STOP_WR) -> FIN -> IDLE.
REQ-019 CFG_WR shall write CTRL = 0x0000000F | (1 << (8+slave)), enabling EN, TX_EN, RX_EN, CS_EN and the selected slave.
REQ-020 In TX_WAIT, tx_ready_o=1 for exactly that state; on handshake, tx_data_i is captured zero-extended into pwdata for the TXDATA write.
REQ-021 STAT_RD shall repeat the STAT read while prdata_i[1] (RX empty)=1, and proceed to RX_RD on the first read returning 0.
REQ-022 The poll counter shall reset per byte; if the POLL_LIMIT-th read still shows empty, the block shall take the error path.
REQ-023 RX_RD captures prdata_i[DATA_WIDTH-1:0]; RX_OUT holds rx_valid_o=1 with stable data until rx_ready_i=1.
REQ-024 The remaining-byte counter shall decrement on each rx handshake; it shall never underflow.
REQ-025 STOP_WR shall write CTRL=0x00000000, releasing chip select.
REQ-026 FIN shall pulse done_o for one cycle; err_o is valid only in that cycle.
REQ-027 The error path applies when pslverr_i=1 at any completed access or on poll timeout: the error is latched, the sequence goes directly to STOP_WR, and FIN reports err_o=1.
REQ-028 A pslverr_i on the STOP_WR access itself shall still end in FIN with err_o=1, with no retry.
REQ-029 tx_valid_i and rx_ready_i shall be ignored outside TX_WAIT and RX_OUT; cmd_valid_i shall be ignored outside IDLE.
REQ-030 Minimum per-byte latency with pready_i=1 and a single poll: 7 cycles (TX 2, STAT 2, RX 2, RX_OUT 1).

Reset
REQ-031 On preset_i=1 the state shall return to IDLE next edge, including mid-transfer, with no completion of an in-flight APB access.
REQ-032 Reset values: cmd_ready_o=0 during reset and 1 the first cycle after; tx_ready_o, rx_valid_o, done_o, err_o, psel_o, penable_o, pwrite_o=0; paddr_o=0; pwdata_o=0; rx_data_o=0; all counters=0.

Structure
REQ-033 Shared package spi_seq_pkg shall hold the register address constants, the CTRL bit positions (EN 0, TX_EN 1, RX_EN 2, CS_EN 3, SS 11:8), the STAT RX-empty bit index, and the state enum.
REQ-034 One sub-module, spi_seq_apb_master, shall own the SETUP/ACCESS/pready handshake; it takes a start/addr/write/wdata request and returns done/rdata/slverr.

Verification
REQ-035 Test 1: len=3, slave=2, tx bytes A5,3C,FF, loopback slave model, pready=1 -> APB writes CTRL=0x40F, three TXDATA/STAT/RXDATA groups, CTRL=0; rx bytes A5,3C,FF; one done_o with err_o=0.
REQ-036 Test 2: len=0 -> done_o one cycle after accept, err_o=0, psel_o never asserted.
REQ-037 Test 3: STAT always returns bit1=1, POLL_LIMIT=8 -> exactly 8 STAT reads, then CTRL=0, done_o with err_o=1.
REQ-038 Test 4: pslverr_i=1 on the second TXDATA write, len=4 -> no further TX/STAT accesses, CTRL=0 written, err_o=1.
REQ-039 Test 5: pready_i low for 3 cycles on each access and rx_ready_i low for 5 cycles -> ACCESS and rx_valid_o are held with stable addr/data, and bytes are correct.
REQ-040 Test 6: preset_i asserted during the ACCESS phase of byte 2 -> the next cycle shows psel_o=0 and all outputs at reset values, and the block then accepts a new command normally.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared constants and types for the SPI transfer sequencer.
// Register map, CTRL/STAT bit positions, FSM state encoding.
package spi_seq_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STAT   = 8'h04;
  localparam logic [7:0] ADDR_TXDATA = 8'h08;
  localparam logic [7:0] ADDR_RXDATA = 8'h0C;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_TX_EN  = 1;
  localparam int CTRL_RX_EN  = 2;
  localparam int CTRL_CS_EN  = 3;
  localparam int CTRL_SS_LSB = 8;
  localparam int CTRL_SS_MSB = 11;

  localparam int STAT_RX_EMPTY = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_WR,
    S_TX_WAIT,
    S_TX_WR,
    S_STAT_RD,
    S_RX_RD,
    S_RX_OUT,
    S_STOP_WR,
    S_FIN
  } seq_state_e;

  // CTRL word enabling the core and the selected chip select
  function automatic logic [31:0] ctrl_cfg(input logic [1:0] slave);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN]    = 1'b1;
    w[CTRL_TX_EN] = 1'b1;
    w[CTRL_RX_EN] = 1'b1;
    w[CTRL_CS_EN] = 1'b1;
    w[CTRL_SS_MSB:CTRL_SS_LSB] = 4'b0001 << slave;
    return w;
  endfunction

endpackage

// File: rtl/spi_seq_apb_master.sv
// Single-outstanding APB master: SETUP then ACCESS until pready.
// Ports: start/addr/write/wdata request in; done/rdata/slverr out.
module spi_seq_apb_master (
  input  logic        pclk_i,
  input  logic        preset_i,
  input  logic        start_i,
  input  logic [7:0]  addr_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        slverr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [7:0]  paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  logic        psel_q;
  logic        pen_q;
  logic        pwrite_q;
  logic [7:0]  paddr_q;
  logic [31:0] pwdata_q;

  assign done_o    = psel_q & pen_q & pready_i;
  assign rdata_o   = prdata_i;
  assign slverr_o  = pslverr_i;
  assign psel_o    = psel_q;
  assign penable_o = pen_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

  // a new start may arrive in the done cycle; it wins over the idle return
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (start_i) begin
      psel_q   <= 1'b1;
      pen_q    <= 1'b0;
      pwrite_q <= write_i;
      paddr_q  <= addr_i;
      pwdata_q <= wdata_i;
    end else if (psel_q && !pen_q) begin
      pen_q <= 1'b1;
    end else if (done_o) begin
      psel_q <= 1'b0;
      pen_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Drives an APB SPI controller through cfg/tx/poll/rx/stop per command.
// Ports: cmd, tx and rx streams, done/err, APB master bus.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [7:0]            cmd_len_i,
  input  logic [1:0]            cmd_slave_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [7:0]            paddr_o,
  output logic [31:0]           pwdata_o,
  input  logic [31:0]           prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  seq_state_e st_q, nx;

  logic [7:0]            rem_q;
  logic [PW-1:0]         poll_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rx_data_q;

  logic        ap_start;
  logic [7:0]  ap_addr;
  logic        ap_write;
  logic [31:0] ap_wdata;
  logic        ap_done;
  logic [31:0] ap_rdata;
  logic        ap_slverr;
  logic        err_set;
  logic        go_stop;
  logic        rx_empty;
  logic        poll_last;
  logic        unused_rdata;

  assign rx_empty     = ap_rdata[STAT_RX_EMPTY];
  assign poll_last    = (poll_q == PW'(POLL_LIMIT - 1));
  assign unused_rdata = ^ap_rdata;

  spi_seq_apb_master u_apb (
    .pclk_i    (pclk_i),
    .preset_i  (preset_i),
    .start_i   (ap_start),
    .addr_i    (ap_addr),
    .write_i   (ap_write),
    .wdata_i   (ap_wdata),
    .done_o    (ap_done),
    .rdata_o   (ap_rdata),
    .slverr_o  (ap_slverr),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .pwrite_o  (pwrite_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );

  // each APB request is launched in the cycle that leaves the prior state,
  // so the new state begins in SETUP
  always_comb begin
    nx       = st_q;
    ap_start = 1'b0;
    ap_addr  = ADDR_CTRL;
    ap_write = 1'b0;
    ap_wdata = '0;
    err_set  = 1'b0;
    go_stop  = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == 8'd0) begin
            nx = S_FIN;
          end else begin
            nx       = S_CFG_WR;
            ap_start = 1'b1;
            ap_write = 1'b1;
            ap_wdata = ctrl_cfg(cmd_slave_i);
          end
        end
      end
      S_CFG_WR: begin
        if (ap_done) begin
          if (ap_slverr) begin
            err_set = 1'b1;
            go_stop = 1'b1;
          end else begin
            nx = S_TX_WAIT;
          end
        end
      end
      S_TX_WAIT: begin
        if (tx_valid_i) begin
          nx       = S_TX_WR;
          ap_start = 1'b1;
          ap_addr  = ADDR_TXDATA;
          ap_write = 1'b1;
          ap_wdata = 32'(tx_data_i);
        end
      end
      S_TX_WR: begin
        if (ap_done) begin
          if (ap_slverr) begin
            err_set = 1'b1;
            go_stop = 1'b1;
          end else begin
            nx       = S_STAT_RD;
            ap_start = 1'b1;
            ap_addr  = ADDR_STAT;
          end
        end
      end
      S_STAT_RD: begin
        if (ap_done) begin
          if (ap_slverr) begin
            err_set = 1'b1;
            go_stop = 1'b1;
          end else if (!rx_empty) begin
            nx       = S_RX_RD;
            ap_start = 1'b1;
            ap_addr  = ADDR_RXDATA;
          end else if (poll_last) begin
            err_set = 1'b1;
            go_stop = 1'b1;
          end else begin
            ap_start = 1'b1;
            ap_addr  = ADDR_STAT;
          end
        end
      end
      S_RX_RD: begin
        if (ap_done) begin
          if (ap_slverr) begin
            err_set = 1'b1;
            go_stop = 1'b1;
          end else begin
            nx = S_RX_OUT;
          end
        end
      end
      S_RX_OUT: begin
        if (rx_ready_i) begin
          if (rem_q <= 8'd1) go_stop = 1'b1;
          else nx = S_TX_WAIT;
        end
      end
      S_STOP_WR: begin
        if (ap_done) begin
          err_set = ap_slverr;
          nx      = S_FIN;
        end
      end
      S_FIN: nx = S_IDLE;
      default: nx = S_IDLE;
    endcase
    if (go_stop) begin
      nx       = S_STOP_WR;
      ap_start = 1'b1;
      ap_addr  = ADDR_CTRL;
      ap_write = 1'b1;
      ap_wdata = '0;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      st_q      <= S_IDLE;
      rem_q     <= '0;
      poll_q    <= '0;
      err_q     <= 1'b0;
      rx_data_q <= '0;
    end else begin
      st_q <= nx;
      if (st_q == S_IDLE && cmd_valid_i) begin
        rem_q <= cmd_len_i;
        err_q <= 1'b0;
      end
      if (st_q == S_RX_OUT && rx_ready_i && rem_q != 8'd0)
        rem_q <= rem_q - 8'd1;
      if (st_q == S_TX_WR)
        poll_q <= '0;
      else if (st_q == S_STAT_RD && ap_done)
        poll_q <= poll_q + PW'(1);
      if (err_set)
        err_q <= 1'b1;
      if (st_q == S_RX_RD && ap_done && !ap_slverr)
        rx_data_q <= ap_rdata[DATA_WIDTH-1:0];
    end
  end

  assign cmd_ready_o = (st_q == S_IDLE) & ~preset_i;
  assign tx_ready_o  = (st_q == S_TX_WAIT);
  assign rx_valid_o  = (st_q == S_RX_OUT);
  assign rx_data_o   = rx_data_q;
  assign done_o      = (st_q == S_FIN);
  assign err_o       = (st_q == S_FIN) & err_q;

endmodule
